fifo_prog: RTL and testbench
============================

// Module: fifo_prog
// PURPOSE
//   Parametrised single-clock FIFO; successor to the basic 8x8 FIFO.
//   - Any depth >= 2, not only powers of two.
//   - Occupancy count output.
//   - Programmable almost-full / almost-empty flags.
//   - Sticky overflow / underflow error flags and a synchronous flush.
//   - Selectable standard or first-word-fall-through (FWFT) read mode.
//   Sits between producer/consumer stages in the same clock domain.
// PARAMETERS
//   WIDTH      8  data word width, >= 1
//   DEPTH      8  number of entries, >= 2, any integer
//   AF_THRESH  6  almost_full asserted when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH  2  almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
//   FWFT       0  0 = standard read, 1 = first-word-fall-through
// PORTS
//   clk           in   1           rising-edge clock
//   rst_n         in   1           async active-low reset
//   clr           in   1           synchronous flush
//   wr_en         in   1           write request
//   wr_data       in   WIDTH       write data
//   rd_en         in   1           read request (FWFT: pop/acknowledge)
//   rd_data       out  WIDTH       read data
//   full          out  1           count == DEPTH
//   empty         out  1           count == 0
//   almost_full   out  1           count >= AF_THRESH
//   almost_empty  out  1           count <= AE_THRESH
//   count         out  CNT_W       occupancy, CNT_W = $clog2(DEPTH+1)
//   overflow      out  1           sticky: write attempted while full
//   underflow     out  1           sticky: read attempted while empty
// BEHAVIOUR
//   - Reset: one clock clk; reset rst_n is asynchronous, active-low.
//     While rst_n = 0: wr_ptr = rd_ptr = 0, count = 0, rd_data = 0,
//     overflow = underflow = 0.
//     Outputs: empty = 1, full = 0, almost_empty = 1,
//     almost_full = (AF_THRESH == 0; never true given the legal range).
//     Memory contents are not reset.
//   - Accept rules: wr_acc = wr_en & ~full; rd_acc = rd_en & ~empty.
//     A rejected request has no effect other than setting its sticky flag.
//     No write-through when full, even with a simultaneous read.
//   - Pointers: address width $clog2(DEPTH).
//     On accept, pointer = (ptr == DEPTH-1) ? 0 : ptr+1.
//     Full/empty come from count, not pointer MSB.
//   - Count: +1 on wr_acc only; -1 on rd_acc only; unchanged on both or neither.
//   - Flags: full, empty, almost_* are combinational from registered count,
//     so they update the cycle after the accepting edge.
//   - Standard mode (FWFT = 0):
//     On rd_acc, rd_data <= mem[rd_ptr] at that edge, i.e. 1-cycle latency.
//     Otherwise rd_data holds its last value (never X/Z).
//   - FWFT mode (FWFT = 1):
//     rd_data = mem[rd_ptr] combinationally whenever ~empty; 0 when empty.
//     A first word written into an empty FIFO is visible the cycle after its
//     write edge. rd_en pops the head.
//   - Simultaneous wr+rd when empty: only the write is accepted; underflow sets.
//   - Simultaneous wr+rd when full: only the read is accepted; overflow sets.
//   - Error flags:
//     overflow <= 1 on wr_en & full; underflow <= 1 on rd_en & empty.
//     Cleared only by rst_n or clr.
//   - clr = 1: at the edge, pointers and count go to 0, error flags clear,
//     rd_data is held. All wr_en/rd_en in that cycle are ignored (clr has priority).
//   - Reset asserted mid-operation: immediate return to reset state;
//     the FIFO reads empty after release.
// STRUCTURE
//   - fifo_pkg:
//     function clog2_safe(n) returns max(1, $clog2(n));
//     typedef of the count width derived from DEPTH.
//   - Sub-module fifo_mem: WIDTH x DEPTH register array, one write port,
//     one asynchronous read port. No reset.
//   - fifo_prog holds pointers, count, flags, read register and mode generate.
//   - Elaboration-time checks: DEPTH >= 2, AF_THRESH <= DEPTH, AE_THRESH < DEPTH.
// TESTING (WIDTH = 8, DEPTH = 5, AF = 4, AE = 1; run both FWFT = 0 and 1)
//   1. Reset, then write 0x11..0x55 on 5 cycles
//      -> count 1..5; almost_empty drops at count 2; almost_full rises at 4;
//         full at 5. 6th write of 0x66 -> rejected, overflow = 1, count stays 5.
//   2. Read all 5 after (1)
//      -> FWFT = 0: rd_data 0x11..0x55 each one cycle after rd_en.
//         FWFT = 1: head visible before rd_en.
//         Then empty = 1; an extra rd -> underflow = 1, rd_data unchanged.
//   3. Wraparound: 3 writes, 3 reads, then 5 writes (ptr wraps 4 -> 0)
//      -> reads return the written order exactly, full at count 5.
//   4. At count 3, wr+rd same cycle for 10 cycles with incrementing data
//      -> count stays 3, data order preserved.
//      At full: wr+rd -> read only, count 4. At empty: wr+rd -> write only, count 1.
//   5. count 3 with overflow set, pulse clr with wr_en = 1
//      -> next cycle count 0, empty 1, overflow 0, no write taken.
//   6. Assert rst_n low mid-burst (count 2), async between edges
//      -> outputs go to reset values immediately, without a clock edge.
//         After release, first write/read returns the new data.

Source files
------------

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the programmable FIFO slice:
//     - clog2_safe : address width helper that never returns 0
//     - cnt_width  : width of an occupancy counter able to hold 0..depth
//     - rd_mode_e  : standard vs first-word-fall-through read mode
// ---------------------------------------------------------------------------
package fifo_pkg;

  typedef enum logic {
    RD_STANDARD = 1'b0,
    RD_FWFT     = 1'b1
  } rd_mode_e;

  // A one-entry address space still needs a 1-bit address.
  function automatic int clog2_safe(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  // The counter must represent DEPTH itself, hence depth+1 values.
  function automatic int cnt_width(input int depth);
    return clog2_safe(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem
//   WIDTH x DEPTH register array with one synchronous write port and one
//   asynchronous read port. Contents are deliberately not reset.
// Ports:
//   clk      in  rising-edge clock
//   wr_en    in  write strobe (already qualified by the caller)
//   wr_addr  in  write address
//   wr_data  in  write data
//   rd_addr  in  read address
//   rd_data  out combinational read data
// ---------------------------------------------------------------------------
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = clog2_safe(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fifo_prog.sv
// ---------------------------------------------------------------------------
// fifo_prog
//   Parametrised single-clock FIFO, any DEPTH >= 2, with occupancy count,
//   programmable almost-full/almost-empty flags, sticky overflow/underflow,
//   synchronous flush and selectable standard / FWFT read mode.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   clr               synchronous flush (beats any wr_en/rd_en that cycle)
//   wr_en, wr_data    write request and data
//   rd_en             read request (FWFT: pop the head)
//   rd_data           read data
//   full, empty       count == DEPTH / count == 0
//   almost_full       count >= AF_THRESH
//   almost_empty      count <= AE_THRESH
//   count             occupancy
//   overflow          sticky: write attempted while full
//   underflow         sticky: read attempted while empty
// ---------------------------------------------------------------------------
module fifo_prog
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW    = clog2_safe(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam rd_mode_e MODE = (FWFT != 0) ? RD_FWFT : RD_STANDARD;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [AW-1:0]    ptr_t;

  localparam ptr_t LAST_PTR = ptr_t'(DEPTH - 1);

  // Elaboration-time parameter checks.
  if (DEPTH < 2) begin : g_chk_depth
    $error("fifo_prog: DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_chk_af
    $error("fifo_prog: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_chk_ae
    $error("fifo_prog: AE_THRESH must be in 0..DEPTH-1");
  end
  if (FWFT != 0 && FWFT != 1) begin : g_chk_fwft
    $error("fifo_prog: FWFT must be 0 or 1");
  end

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q,  count_d;
  logic overflow_q,  overflow_d;
  logic underflow_q, underflow_d;

  logic             wr_acc;
  logic             rd_acc;
  logic [WIDTH-1:0] mem_rd_data;

  // Flags derive from the registered count so they work for any DEPTH.
  assign full         = (count_q == cnt_t'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= cnt_t'(AF_THRESH));
  assign almost_empty = (count_q <= cnt_t'(AE_THRESH));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Full blocks writes even with a simultaneous read: no write-through.
  assign wr_acc = wr_en & ~full  & ~clr;
  assign rd_acc = rd_en & ~empty & ~clr;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | (wr_en & full);
    underflow_d = underflow_q | (rd_en & empty);

    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + ptr_t'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + ptr_t'(1);
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase

    if (clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q),
    .rd_data (mem_rd_data)
  );

  if (MODE == RD_FWFT) begin : g_fwft
    // Head is presented directly; forced to 0 when empty so stale or
    // never-written memory is not exposed.
    assign rd_data = empty ? '0 : mem_rd_data;
  end else begin : g_std
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    // Captures the head only on an accepted read; holds across flush.
    always_comb begin
      rd_data_d = rd_data_q;
      if (rd_acc) begin
        rd_data_d = mem_rd_data;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_q <= '0;
      end else begin
        rd_data_q <= rd_data_d;
      end
    end

    assign rd_data = rd_data_q;
  end

endmodule

// File: tb/tb_fifo_prog.sv
// ---------------------------------------------------------------------------
// tb_fifo_prog
//   Drives the same directed stimulus into a standard-mode and an FWFT-mode
//   instance of fifo_prog (WIDTH 8, DEPTH 5, AF 4, AE 1) and checks both.
// ---------------------------------------------------------------------------
module tb_fifo_prog;

  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;

  logic [WIDTH-1:0] s_rd_data, f_rd_data;
  logic             s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic             f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [CNT_W-1:0] s_count, f_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fifo_prog #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(4), .AE_THRESH(1), .FWFT(0)
  ) u_std (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(s_rd_data), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_udf)
  );

  fifo_prog #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(4), .AE_THRESH(1), .FWFT(1)
  ) u_fwft (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(f_rd_data), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf)
  );

  // Status vector: {count, full, empty, almost_full, almost_empty, ovf, udf}
  wire [8:0] s_status = {s_count, s_full, s_empty, s_af, s_ae, s_ovf, s_udf};
  wire [8:0] f_status = {f_count, f_full, f_empty, f_af, f_ae, f_ovf, f_udf};

  function automatic logic [8:0] expStatus(input int cnt, input bit ovf, input bit udf);
    return {3'(cnt), (cnt == 5), (cnt == 0), (cnt >= 4), (cnt <= 1), ovf, udf};
  endfunction

  // Inputs change 1ns after an edge, the edge is taken, and outputs are
  // sampled 1ns after it; inputs then return to idle.
  task automatic applyStimulus(input bit wr, input bit rd, input logic [7:0] data, input bit fl);
    wr_en   = wr;
    rd_en   = rd;
    wr_data = data;
    clr     = fl;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr     = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkBoth(input string tag, input int cnt, input bit ovf, input bit udf);
    checkOutput({"std.", tag}, 32'(s_status), 32'(expStatus(cnt, ovf, udf)));
    checkOutput({"fwft.", tag}, 32'(f_status), 32'(expStatus(cnt, ovf, udf)));
  endtask

  initial begin
    rst_n   = 1'b0;
    clr     = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    #2;
    $display("[TB] reset");
    checkBoth("reset.status", 0, 0, 0);
    checkOutput("std.reset.rd_data", 32'(s_rd_data), 32'h0);
    checkOutput("fwft.reset.rd_data", 32'(f_rd_data), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1. Fill with 0x11..0x55, then one rejected write.
    $display("[TB] fill");
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1, 0, 8'(k * 8'h11), 0);
      checkBoth($sformatf("fill%0d", k), k, 0, 0);
    end
    checkOutput("fwft.fill.head", 32'(f_rd_data), 32'h11);
    applyStimulus(1, 0, 8'h66, 0);
    checkBoth("overflow", 5, 1, 0);
    checkOutput("fwft.overflow.head", 32'(f_rd_data), 32'h11);

    // 2. Drain all five, then one read too many.
    $display("[TB] drain");
    for (int k = 1; k <= 5; k++) begin
      checkOutput($sformatf("fwft.drain%0d.head", k), 32'(f_rd_data), 32'(k * 8'h11));
      applyStimulus(0, 1, 8'h00, 0);
      checkOutput($sformatf("std.drain%0d.rd_data", k), 32'(s_rd_data), 32'(k * 8'h11));
      checkBoth($sformatf("drain%0d", k), 5 - k, 1, 0);
    end
    checkOutput("fwft.drained.rd_data", 32'(f_rd_data), 32'h0);
    applyStimulus(0, 1, 8'h00, 0);
    checkBoth("underflow", 0, 1, 1);
    checkOutput("std.underflow.rd_data", 32'(s_rd_data), 32'h55);
    applyStimulus(0, 0, 8'h00, 1);
    checkBoth("clr1", 0, 0, 0);

    // 3. Wraparound: 3 in, 3 out, then 5 in starting mid-array.
    $display("[TB] wrap");
    for (int k = 0; k < 3; k++) applyStimulus(1, 0, 8'(8'hA0 + k), 0);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("fwft.wrapA%0d.head", k), 32'(f_rd_data), 32'(8'hA0 + k));
      applyStimulus(0, 1, 8'h00, 0);
      checkOutput($sformatf("std.wrapA%0d.rd_data", k), 32'(s_rd_data), 32'(8'hA0 + k));
    end
    for (int k = 0; k < 5; k++) applyStimulus(1, 0, 8'(8'hB0 + k), 0);
    checkBoth("wrap.full", 5, 0, 0);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("fwft.wrapB%0d.head", k), 32'(f_rd_data), 32'(8'hB0 + k));
      applyStimulus(0, 1, 8'h00, 0);
      checkOutput($sformatf("std.wrapB%0d.rd_data", k), 32'(s_rd_data), 32'(8'hB0 + k));
    end
    checkBoth("wrap.empty", 0, 0, 0);

    // 4. Steady-state simultaneous read/write at count 3.
    $display("[TB] simultaneous");
    for (int k = 0; k < 3; k++) applyStimulus(1, 0, 8'(8'hC0 + k), 0);
    for (int k = 0; k < 10; k++) begin
      automatic logic [7:0] exp_d = (k < 3) ? 8'(8'hC0 + k) : 8'(8'hD0 + k - 3);
      checkOutput($sformatf("fwft.rw%0d.head", k), 32'(f_rd_data), 32'(exp_d));
      applyStimulus(1, 1, 8'(8'hD0 + k), 0);
      checkOutput($sformatf("std.rw%0d.rd_data", k), 32'(s_rd_data), 32'(exp_d));
      checkBoth($sformatf("rw%0d", k), 3, 0, 0);
    end
    // Holds D7, D8, D9; top up to full.
    applyStimulus(1, 0, 8'hE0, 0);
    applyStimulus(1, 0, 8'hE1, 0);
    checkBoth("rw.full", 5, 0, 0);
    applyStimulus(1, 1, 8'hEE, 0);
    checkBoth("rw.at_full", 4, 1, 0);
    checkOutput("std.rw.at_full.rd_data", 32'(s_rd_data), 32'hD7);
    checkOutput("fwft.rw.at_full.head", 32'(f_rd_data), 32'hD8);
    applyStimulus(0, 1, 8'h00, 0);
    applyStimulus(0, 1, 8'h00, 0);
    applyStimulus(0, 1, 8'h00, 0);
    checkOutput("fwft.rw.last.head", 32'(f_rd_data), 32'hE1);
    applyStimulus(0, 1, 8'h00, 0);
    checkOutput("std.rw.last.rd_data", 32'(s_rd_data), 32'hE1);
    checkBoth("rw.empty", 0, 1, 0);
    applyStimulus(1, 1, 8'hF0, 0);
    checkBoth("rw.at_empty", 1, 1, 1);
    checkOutput("std.rw.at_empty.rd_data", 32'(s_rd_data), 32'hE1);
    checkOutput("fwft.rw.at_empty.head", 32'(f_rd_data), 32'hF0);

    // 5. Flush at count 3 with overflow set and a concurrent write.
    $display("[TB] flush");
    applyStimulus(1, 0, 8'hF1, 0);
    applyStimulus(1, 0, 8'hF2, 0);
    checkBoth("pre_clr", 3, 1, 1);
    applyStimulus(1, 0, 8'h77, 1);
    checkBoth("clr2", 0, 0, 0);
    checkOutput("std.clr.rd_data_held", 32'(s_rd_data), 32'hE1);
    checkOutput("fwft.clr.rd_data", 32'(f_rd_data), 32'h0);
    applyStimulus(1, 0, 8'h88, 0);
    checkOutput("fwft.post_clr.head", 32'(f_rd_data), 32'h88);
    applyStimulus(0, 1, 8'h00, 0);
    checkOutput("std.post_clr.rd_data", 32'(s_rd_data), 32'h88);
    checkBoth("post_clr", 0, 0, 0);

    // 6. Asynchronous reset between edges at count 2.
    $display("[TB] async reset");
    applyStimulus(1, 0, 8'h91, 0);
    applyStimulus(1, 0, 8'h92, 0);
    checkBoth("pre_rst", 2, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkBoth("async_rst", 0, 0, 0);
    checkOutput("std.async_rst.rd_data", 32'(s_rd_data), 32'h0);
    checkOutput("fwft.async_rst.rd_data", 32'(f_rd_data), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1, 0, 8'h5A, 0);
    checkOutput("fwft.post_rst.head", 32'(f_rd_data), 32'h5A);
    applyStimulus(0, 1, 8'h00, 0);
    checkOutput("std.post_rst.rd_data", 32'(s_rd_data), 32'h5A);
    checkBoth("post_rst", 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
